ex_mem_alu_stage: RTL and testbench

- Execute-stage datapath: 32-bit ALU driven by the 4-bit operation code from the ALU control unit, followed by the EX/MEM pipeline register.
- Receives operands and control from ID/EX; registers result, zero flag, store data, destination and MEM/WB control for the memory stage.
- Honours the hazard unit's stall (hold) and flush (bubble) requests.
- Also exposes the unregistered ALU result for the forwarding unit.

---
 rtl/ex_mem_alu_stage.sv | 134 +++++++++++++
 tb/tb_ex_mem_alu_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_alu_stage
//
// Execute stage of the pipeline: a combinational 32-bit ALU selected by the
// 4-bit operation code from ALU control, followed by the EX/MEM pipeline
// register that carries the result to the memory stage.
//
// Ports:
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_operation           ALU op code (see table in the ALU block)
//   i_op_a, i_op_b        operands after forwarding / immediate mux
//   i_shamt               instruction shamt field (SLL/SRL/SRA)
//   i_store_data          rt value for stores, passed through
//   i_rd_addr             destination register, passed through
//   i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg
//                         MEM/WB control, passed through
//   i_valid               ID/EX holds a real instruction
//   i_stall, i_flush      hazard-unit hold / bubble requests
//   o_alu_comb            unregistered ALU result for the forwarding unit
//   o_result, o_zero, o_store_data, o_rd_addr, o_reg_write, o_mem_read,
//   o_mem_write, o_mem_to_reg, o_valid
//                         EX/MEM register contents
//
// Pipeline-control semantics: i_valid only qualifies the instruction; it is
// stored and forwarded as-is and never gates the controls (decode already
// did that). On each rising edge the register is updated with priority
// reset > flush > stall > load. Reset and flush both load a bubble (all
// zero, o_zero = 1); stall holds every registered output; otherwise the
// register captures the current ALU result and pass-through inputs.
// ---------------------------------------------------------------------------
module ex_mem_alu_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [3:0]         i_operation,
  input  logic [NB_DATA-1:0] i_op_a,
  input  logic [NB_DATA-1:0] i_op_b,
  input  logic [4:0]         i_shamt,
  input  logic [NB_DATA-1:0] i_store_data,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_mem_to_reg,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic [NB_DATA-1:0] o_alu_comb,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic [NB_DATA-1:0] o_store_data,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_valid
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLLV = 4'd10;
  localparam logic [3:0] OP_SRLV = 4'd11;
  localparam logic [3:0] OP_SRAV = 4'd12;
  localparam logic [3:0] OP_LUI  = 4'd13;

  logic [4:0]         var_amt;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_zero;

  // Variable shifts take their amount from the low 5 bits of operand A.
  assign var_amt = i_op_a[4:0];

  always_comb begin
    alu_res = '0;
    unique case (i_operation)
      OP_ADD:  alu_res = i_op_a + i_op_b;
      OP_SUB:  alu_res = i_op_a - i_op_b;
      OP_AND:  alu_res = i_op_a & i_op_b;
      OP_OR:   alu_res = i_op_a | i_op_b;
      OP_XOR:  alu_res = i_op_a ^ i_op_b;
      OP_NOR:  alu_res = ~(i_op_a | i_op_b);
      OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_SLL:  alu_res = i_op_b << i_shamt;
      OP_SRL:  alu_res = i_op_b >> i_shamt;
      OP_SRA:  alu_res = $signed(i_op_b) >>> i_shamt;
      OP_SLLV: alu_res = i_op_b << var_amt;
      OP_SRLV: alu_res = i_op_b >> var_amt;
      OP_SRAV: alu_res = $signed(i_op_b) >>> var_amt;
      OP_LUI:  alu_res = {i_op_b[15:0], {(NB_DATA-16){1'b0}}};
      default: alu_res = '0;  // codes 14 and 15 are unused
    endcase
  end

  assign alu_zero   = (alu_res == '0);
  assign o_alu_comb = alu_res;

  // EX/MEM register. Reset and flush load the same bubble; reset is listed
  // first so it wins over everything, flush wins over a simultaneous stall.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      o_result     <= '0;
      o_zero       <= 1'b1;
      o_store_data <= '0;
      o_rd_addr    <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_valid      <= 1'b0;
    end else if (!i_stall) begin
      o_result     <= alu_res;
      o_zero       <= alu_zero;
      o_store_data <= i_store_data;
      o_rd_addr    <= i_rd_addr;
      o_reg_write  <= i_reg_write;
      o_mem_read   <= i_mem_read;
      o_mem_write  <= i_mem_write;
      o_mem_to_reg <= i_mem_to_reg;
      o_valid      <= i_valid;
    end
  end

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_alu_stage
//
// Directed and random stimulus for ex_mem_alu_stage. Each driven cycle the
// expected EX/MEM contents are computed from an independent ALU model and a
// register model, pushed to exp_q, and popped/compared after the edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_alu_stage;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  // {valid, reg_write, mem_read, mem_write, mem_to_reg, rd, store, zero, result}
  localparam int W = 1 + 4 + NB_REG + NB_DATA + 1 + NB_DATA;

  // ---------------- clock / reset block ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic               i_reset;
  logic [3:0]         i_operation;
  logic [NB_DATA-1:0] i_op_a, i_op_b, i_store_data;
  logic [4:0]         i_shamt;
  logic [NB_REG-1:0]  i_rd_addr;
  logic               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
  logic               i_valid, i_stall, i_flush;
  logic [NB_DATA-1:0] o_alu_comb, o_result, o_store_data;
  logic               o_zero;
  logic [NB_REG-1:0]  o_rd_addr;
  logic               o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_valid;

  ex_mem_alu_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_operation(i_operation),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_shamt(i_shamt),
    .i_store_data(i_store_data), .i_rd_addr(i_rd_addr),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
    .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .o_alu_comb(o_alu_comb), .o_result(o_result), .o_zero(o_zero),
    .o_store_data(o_store_data), .o_rd_addr(o_rd_addr),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_valid(o_valid)
  );

  logic [W-1:0] obs;
  assign obs = {o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                o_rd_addr, o_store_data, o_zero, o_result};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_reg;
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU written independently of the RTL (loop-based arithmetic
  // shift, sign-split signed compare).
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic [4:0]  amt;
    amt = (op >= 4'd10) ? a[4:0] : sh;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + ~b + 32'd1;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a & ~b;
      4'd6:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd7, 4'd10: r = b << amt;
      4'd8, 4'd11: r = b >> amt;
      4'd9, 4'd12: begin
        r = b;
        for (int i = 0; i < 32; i++) if (i < amt) r = {r[31], r[31:1]};
      end
      4'd13: r = b << 16;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  localparam logic [W-1:0] BUBBLE = {{(W-NB_DATA-1){1'b0}}, 1'b1, {NB_DATA{1'b0}}};

  // ---------------- driver tasks ----------------
  // Randomises pass-through fields and sets the ALU inputs.
  task automatic set_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    i_operation  = op;
    i_op_a       = a;
    i_op_b       = b;
    i_shamt      = sh;
    i_store_data = $urandom;
    i_rd_addr    = NB_REG'($urandom_range(0, 31));
    i_reg_write  = 1'($urandom_range(0, 1));
    i_mem_read   = 1'($urandom_range(0, 1));
    i_mem_write  = 1'($urandom_range(0, 1));
    i_mem_to_reg = 1'($urandom_range(0, 1));
    i_valid      = 1'($urandom_range(0, 1));
  endtask

  // Checks the combinational result, predicts the register, clocks once,
  // then compares the registered outputs against the popped expectation.
  task automatic cycle(input string tag);
    logic [31:0]  r;
    logic [W-1:0] nxt;
    logic [W-1:0] e;
    #1;
    r = alu_model(i_operation, i_op_a, i_op_b, i_shamt);
    check({tag, "_comb"}, W'(o_alu_comb), W'(r));
    if (i_reset || i_flush) nxt = BUBBLE;
    else if (i_stall)       nxt = model_reg;
    else nxt = {i_valid, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
                i_rd_addr, i_store_data, (r == 32'd0), r};
    exp_q.push_back(nxt);
    model_reg = nxt;
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, W'(1), W'(0));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_reg"}, obs, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reg = BUBBLE;
    i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    set_op(4'd0, 32'h1234, 32'h1, 5'd3);
    i_valid = 1'b1; i_reg_write = 1'b1; i_rd_addr = 5'd7; i_store_data = 32'hDEAD;

    // Reset held 2 cycles with nonzero inputs.
    cycle("reset0");
    cycle("reset1");
    check("reset_zero",  W'(o_zero),   W'(1));
    check("reset_valid", W'(o_valid),  W'(0));
    check("reset_res",   W'(o_result), W'(0));
    i_reset = 1'b0;

    set_op(4'd0, 32'h7FFFFFFF, 32'd1, 5'd0);   cycle("add_ovf");
    check("add_ovf_val", W'(o_result), W'(32'h80000000));
    set_op(4'd1, 32'd5, 32'd5, 5'd0);          cycle("sub_eq");
    check("sub_eq_zero", W'(o_zero), W'(1));
    set_op(4'd6, 32'hFFFFFFFF, 32'd1, 5'd0);   cycle("slt_neg");
    check("slt_neg_val", W'(o_result), W'(1));
    set_op(4'd9, 32'd0, 32'h80000000, 5'd4);   cycle("sra");
    check("sra_val", W'(o_result), W'(32'hF8000000));
    set_op(4'd11, 32'h24, 32'hF0, 5'd0);       cycle("srlv");
    check("srlv_val", W'(o_result), W'(32'h0F));
    set_op(4'd13, 32'd0, 32'h00001234, 5'd0);  cycle("lui");
    check("lui_val", W'(o_result), W'(32'h12340000));
    set_op(4'd14, 32'h55, 32'h66, 5'd1);       cycle("op14");
    check("op14_val", W'(o_result), W'(0));

    // Stall: load 0xAA, then hold for 3 cycles while inputs change.
    set_op(4'd3, 32'hAA, 32'h0, 5'd0);
    i_reg_write = 1'b1; i_valid = 1'b1;        cycle("stall_load");
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_op(4'($urandom_range(0, 13)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      cycle("stall_hold");
      check("stall_res", W'(o_result), W'(32'hAA));
      check("stall_rw",  W'(o_reg_write), W'(1));
    end

    // Flush together with stall.
    i_flush = 1'b1;
    set_op(4'd0, 32'd3, 32'd4, 5'd0);
    i_reg_write = 1'b1; i_valid = 1'b1;        cycle("flush_stall");
    check("flush_rw",    W'(o_reg_write), W'(0));
    check("flush_valid", W'(o_valid),     W'(0));
    check("flush_res",   W'(o_result),    W'(0));
    check("flush_zero",  W'(o_zero),      W'(1));
    i_flush = 1'b0; i_stall = 1'b0;

    // Back-to-back.
    set_op(4'd0, 32'd2, 32'd3, 5'd0);          cycle("b2b_add");
    check("b2b_add_val", W'(o_result), W'(5));
    set_op(4'd2, 32'hF0, 32'h3C, 5'd0);        cycle("b2b_and");
    check("b2b_and_val", W'(o_result), W'(32'h30));
    set_op(4'd5, 32'd0, 32'd0, 5'd0);          cycle("b2b_nor");
    check("b2b_nor_val", W'(o_result), W'(32'hFFFFFFFF));

    // Random traffic with occasional stall / flush / reset.
    for (int k = 0; k < 60; k++) begin
      set_op(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      i_stall = ($urandom_range(0, 3) == 0);
      i_flush = ($urandom_range(0, 7) == 0);
      i_reset = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    i_stall = 1'b0; i_flush = 1'b0; i_reset = 1'b0;

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
